serdesphy_link_ctrl: RTL and testbench
======================================

Name: serdesphy_link_ctrl

Overview:
Link bring-up sequencer for the SerDes PHY, in the clk_ref_24m domain next to the CSR block.
- Sequences PLL reset, lock wait, TX enable, CDR reset, lock wait and RX word alignment.
- Supervises the up link and re-runs the failing stage on loss of lock or alignment.
- Retries timed-out stages a bounded number of times, then latches a fail state for software.

Parameters:
PLL_RST_CYC, 24, cycles pll_rst held high (1 us at 24 MHz)
PLL_LOCK_TMO, 2400, max cycles in PLL_WAIT before timeout (100 us)
CDR_RST_CYC, 24, cycles cdr_rst held high
CDR_LOCK_TMO, 4800, max cycles in CDR_WAIT before timeout
ALIGN_TMO, 2400, max cycles in ALIGN before timeout
LOCK_FILT, 8, consecutive high cycles required to accept pll_lock/cdr_lock/rx_aligned
MAX_RETRY, 3, timeouts tolerated before FAIL (1..7)

Ports:
clk_ref_24m  in  1  24 MHz reference clock; only clock
rst  in  1  synchronous, active-high reset
link_start  in  1  CSR request to bring link up; level-sensitive
power_good  in  1  from POR; low forces IDLE
pll_lock  in  1  PLL lock, already synchronous to clk_ref_24m
cdr_lock  in  1  CDR lock, pre-synchronised
rx_aligned  in  1  RX alignment achieved, pre-synchronised
pll_rst  out  1  PLL reset
cdr_rst  out  1  CDR reset
tx_en  out  1  TX datapath enable
rx_en  out  1  RX datapath enable
rx_align_rst  out  1  alignment FSM reset
link_up  out  1  link operational
link_fail  out  1  retries exhausted; sticky until link_start low
link_state  out  3  current state encoding (CSR readback)
retry_cnt  out  3  timeouts since last IDLE/LINK_UP

Behaviour:
- All logic on posedge clk_ref_24m. rst=1 forces the reset values on the next edge:
  - state=IDLE, all counters 0
  - pll_rst=1, cdr_rst=1, rx_align_rst=1
  - tx_en=0, rx_en=0, link_up=0, link_fail=0, retry_cnt=0
- Outputs are registered Moore decodes and are valid in the first cycle a state is entered.
- Encoding: IDLE=0, PLL_RST=1, PLL_WAIT=2, CDR_RST=3, CDR_WAIT=4, ALIGN=5, LINK_UP=6, FAIL=7.
- Output table; signals not listed are 0:
  - IDLE: pll_rst=1, cdr_rst=1, rx_align_rst=1
  - PLL_RST: pll_rst=1, cdr_rst=1, rx_align_rst=1
  - PLL_WAIT: cdr_rst=1, rx_align_rst=1
  - CDR_RST: cdr_rst=1, tx_en=1, rx_align_rst=1
  - CDR_WAIT: tx_en=1, rx_en=1, rx_align_rst=1
  - ALIGN: tx_en=1, rx_en=1
  - LINK_UP: tx_en=1, rx_en=1, link_up=1
  - FAIL: same as IDLE, plus link_fail=1
- Transitions:
  - IDLE -> PLL_RST when link_start and power_good are both 1.
  - PLL_RST -> PLL_WAIT after exactly PLL_RST_CYC cycles.
  - PLL_WAIT -> CDR_RST when the filtered pll_lock is accepted.
  - CDR_RST -> CDR_WAIT after exactly CDR_RST_CYC cycles.
  - CDR_WAIT -> ALIGN when the filtered cdr_lock is accepted.
  - ALIGN -> LINK_UP when the filtered rx_aligned is accepted; retry_cnt clears on entry to LINK_UP.
- Lock filter: one shared counter, cleared on every state entry and whenever the monitored input is 0. Accept when the count reaches LOCK_FILT. Minimum PLL_WAIT dwell is therefore LOCK_FILT cycles.
- Timeouts: one shared counter, cleared on state entry.
  - Expiry in PLL_WAIT, CDR_WAIT or ALIGN increments retry_cnt.
  - If the pre-increment retry_cnt == MAX_RETRY-1, go to FAIL.
  - Otherwise restart the failing stage: PLL_WAIT -> PLL_RST; CDR_WAIT or ALIGN -> CDR_RST.
  - If lock is accepted and the timeout expires in the same cycle, acceptance wins.
- LINK_UP monitoring, unfiltered, acts on the next cycle; retry_cnt is unchanged on these exits:
  - pll_lock=0 -> PLL_RST.
  - Otherwise cdr_lock=0 or rx_aligned=0 -> CDR_RST.
- Global abort: link_start=0 or power_good=0 in any state -> IDLE on the next edge. Counters and retry_cnt clear. Abort overrides every other transition.
- FAIL is held while link_start=1; link_start=0 -> IDLE, which clears link_fail.
- Counter width is $clog2 of the largest timing parameter plus 1. Counters saturate and never wrap.

Decomposition:
- Package serdesphy_link_pkg holds:
  - the link_state_e enum (3-bit encodings above)
  - the default timing constants
  - the state-to-output decode function
- One sub-module: serdesphy_lock_filter (the consecutive-high counter with clear; output accepted), instantiated once with a muxed input.

Test Plan:
Use bench overrides PLL_RST_CYC=4, PLL_LOCK_TMO=20, CDR_RST_CYC=4, CDR_LOCK_TMO=20, ALIGN_TMO=20, LOCK_FILT=3, MAX_RETRY=3.
- Happy path: all inputs held high, link_start rises at cycle 0.
  - pll_rst high for 4 cycles, tx_en rises with CDR_RST, link_up=1 about 20 cycles after the start.
  - link_state visits 1,2,3,4,5,6 in order.
- Lock glitch: pll_lock pattern 1,1,0,1,1,1 in PLL_WAIT -> acceptance only on the third consecutive high; no early CDR_RST.
- Timeout retry: pll_lock held 0.
  - Three expiries give retry_cnt 1, then 2, then FAIL with link_fail=1 and pll_rst=1.
  - link_start low -> IDLE, link_fail=0, retry_cnt=0.
- Loss in LINK_UP:
  - drop cdr_lock for 1 cycle -> CDR_RST, tx_en stays 1, rx_en=0.
  - drop pll_lock -> PLL_RST, tx_en=0.
- Abort and reset mid-sequence:
  - power_good=0 in CDR_WAIT -> IDLE next cycle with all reset outputs.
  - rst=1 in LINK_UP -> reset values next edge, with link_start still high.

Source files
------------

// File: rtl/serdesphy_link_pkg.sv
// Shared types, default timing and state-to-output decode
// for the SerDes PHY link bring-up sequencer.
package serdesphy_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLL_RST  = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_CDR_RST  = 3'd3,
        ST_CDR_WAIT = 3'd4,
        ST_ALIGN    = 3'd5,
        ST_LINK_UP  = 3'd6,
        ST_FAIL     = 3'd7
    } link_state_e;

    typedef struct packed {
        logic pll_rst;
        logic cdr_rst;
        logic tx_en;
        logic rx_en;
        logic rx_align_rst;
        logic link_up;
        logic link_fail;
    } link_out_t;

    localparam int DEF_PLL_RST_CYC  = 24;
    localparam int DEF_PLL_LOCK_TMO = 2400;
    localparam int DEF_CDR_RST_CYC  = 24;
    localparam int DEF_CDR_LOCK_TMO = 4800;
    localparam int DEF_ALIGN_TMO    = 2400;
    localparam int DEF_LOCK_FILT    = 8;
    localparam int DEF_MAX_RETRY    = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic link_out_t decode_state(input link_state_e s);
        link_out_t o;
        o = '0;
        unique case (s)
            ST_IDLE, ST_PLL_RST: begin
                o.pll_rst      = 1'b1;
                o.cdr_rst      = 1'b1;
                o.rx_align_rst = 1'b1;
            end
            ST_PLL_WAIT: begin
                o.cdr_rst      = 1'b1;
                o.rx_align_rst = 1'b1;
            end
            ST_CDR_RST: begin
                o.cdr_rst      = 1'b1;
                o.tx_en        = 1'b1;
                o.rx_align_rst = 1'b1;
            end
            ST_CDR_WAIT: begin
                o.tx_en        = 1'b1;
                o.rx_en        = 1'b1;
                o.rx_align_rst = 1'b1;
            end
            ST_ALIGN: begin
                o.tx_en = 1'b1;
                o.rx_en = 1'b1;
            end
            ST_LINK_UP: begin
                o.tx_en   = 1'b1;
                o.rx_en   = 1'b1;
                o.link_up = 1'b1;
            end
            ST_FAIL: begin
                o.pll_rst      = 1'b1;
                o.cdr_rst      = 1'b1;
                o.rx_align_rst = 1'b1;
                o.link_fail    = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// Consecutive-high qualifier for lock/alignment indications;
// accepted asserts in the cycle the FILT-th consecutive high is seen.
module serdesphy_lock_filter #(
    parameter int FILT = 8,
    parameter int CW   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sig_in,
    output logic accepted
);

    localparam logic [CW-1:0] ACC_LIM = CW'(FILT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !sig_in) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign accepted = sig_in && (cnt_q >= ACC_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serdesphy_link_ctrl.sv
// SerDes PHY link bring-up sequencer: PLL/CDR reset and lock,
// RX alignment, link supervision and bounded timeout retries.
module serdesphy_link_ctrl
    import serdesphy_link_pkg::*;
#(
    parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
    parameter int PLL_LOCK_TMO = DEF_PLL_LOCK_TMO,
    parameter int CDR_RST_CYC  = DEF_CDR_RST_CYC,
    parameter int CDR_LOCK_TMO = DEF_CDR_LOCK_TMO,
    parameter int ALIGN_TMO    = DEF_ALIGN_TMO,
    parameter int LOCK_FILT    = DEF_LOCK_FILT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       clk_ref_24m,
    input  logic       rst,
    input  logic       link_start,
    input  logic       power_good,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       rx_aligned,
    output logic       pll_rst,
    output logic       cdr_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       rx_align_rst,
    output logic       link_up,
    output logic       link_fail,
    output logic [2:0] link_state,
    output logic [2:0] retry_cnt
);

    localparam int MAX_P = max_int(
        max_int(max_int(PLL_RST_CYC, PLL_LOCK_TMO),
                max_int(CDR_RST_CYC, CDR_LOCK_TMO)),
        max_int(ALIGN_TMO, LOCK_FILT));
    localparam int CW = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] PLL_RST_LIM = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] PLL_TMO_LIM = CW'(PLL_LOCK_TMO - 1);
    localparam logic [CW-1:0] CDR_RST_LIM = CW'(CDR_RST_CYC - 1);
    localparam logic [CW-1:0] CDR_TMO_LIM = CW'(CDR_LOCK_TMO - 1);
    localparam logic [CW-1:0] ALN_TMO_LIM = CW'(ALIGN_TMO - 1);
    localparam logic [CW-1:0] TMO_MAX     = '1;
    localparam logic [2:0]    RETRY_LAST  = 3'(MAX_RETRY - 1);

    link_state_e   state_q, state_d;
    link_state_e   restart_st;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [2:0]    retry_q, retry_d;
    link_out_t     out_q, out_d;
    logic          filt_in, filt_acc, clr, abort, expire;

    // Only the wait states feed the shared filter; elsewhere it idles at 0
    always_comb begin
        filt_in = 1'b0;
        unique case (state_q)
            ST_PLL_WAIT: filt_in = pll_lock;
            ST_CDR_WAIT: filt_in = cdr_lock;
            ST_ALIGN:    filt_in = rx_aligned;
            default:     filt_in = 1'b0;
        endcase
    end

    serdesphy_lock_filter #(
        .FILT (LOCK_FILT),
        .CW   (CW)
    ) u_lock_filter (
        .clk      (clk_ref_24m),
        .rst      (rst),
        .clr      (clr),
        .sig_in   (filt_in),
        .accepted (filt_acc)
    );

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        expire     = 1'b0;
        restart_st = ST_PLL_RST;
        abort      = !link_start || !power_good;
        unique case (state_q)
            ST_IDLE: begin
                if (link_start && power_good) state_d = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (tmo_q >= PLL_RST_LIM) state_d = ST_PLL_WAIT;
            end
            ST_PLL_WAIT: begin
                if (filt_acc) state_d = ST_CDR_RST;
                else if (tmo_q >= PLL_TMO_LIM) expire = 1'b1;
            end
            ST_CDR_RST: begin
                if (tmo_q >= CDR_RST_LIM) state_d = ST_CDR_WAIT;
            end
            ST_CDR_WAIT: begin
                restart_st = ST_CDR_RST;
                if (filt_acc) state_d = ST_ALIGN;
                else if (tmo_q >= CDR_TMO_LIM) expire = 1'b1;
            end
            ST_ALIGN: begin
                restart_st = ST_CDR_RST;
                if (filt_acc) state_d = ST_LINK_UP;
                else if (tmo_q >= ALN_TMO_LIM) expire = 1'b1;
            end
            ST_LINK_UP: begin
                if (!pll_lock) state_d = ST_PLL_RST;
                else if (!cdr_lock || !rx_aligned) state_d = ST_CDR_RST;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
        endcase

        if (expire) begin
            retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
            state_d = (retry_q == RETRY_LAST) ? ST_FAIL : restart_st;
        end
        if (state_d == ST_LINK_UP && state_q != ST_LINK_UP) retry_d = '0;
        if (abort) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end

        clr   = abort || (state_d != state_q);
        tmo_d = clr ? '0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1);
        out_d = decode_state(state_d);
    end

    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            retry_q <= '0;
            out_q   <= decode_state(ST_IDLE);
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign pll_rst      = out_q.pll_rst;
    assign cdr_rst      = out_q.cdr_rst;
    assign tx_en        = out_q.tx_en;
    assign rx_en        = out_q.rx_en;
    assign rx_align_rst = out_q.rx_align_rst;
    assign link_up      = out_q.link_up;
    assign link_fail    = out_q.link_fail;
    assign link_state   = state_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// Bench for serdesphy_link_ctrl: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_serdesphy_link_ctrl;

    localparam int PRC  = 4;
    localparam int PTMO = 20;
    localparam int CRC  = 4;
    localparam int CTMO = 20;
    localparam int ATMO = 20;
    localparam int LF   = 3;
    localparam int MR   = 3;

    logic       clk_ref_24m = 1'b0;
    logic       rst, link_start, power_good;
    logic       pll_lock, cdr_lock, rx_aligned;
    logic       pll_rst, cdr_rst, tx_en, rx_en, rx_align_rst;
    logic       link_up, link_fail;
    logic [2:0] link_state, retry_cnt;

    int checks = 0;
    int errors = 0;
    int m_state, m_dwell, m_run, m_retry;

    always #5 clk_ref_24m = ~clk_ref_24m;

    serdesphy_link_ctrl #(
        .PLL_RST_CYC  (PRC),
        .PLL_LOCK_TMO (PTMO),
        .CDR_RST_CYC  (CRC),
        .CDR_LOCK_TMO (CTMO),
        .ALIGN_TMO    (ATMO),
        .LOCK_FILT    (LF),
        .MAX_RETRY    (MR)
    ) dut (
        .clk_ref_24m  (clk_ref_24m),
        .rst          (rst),
        .link_start   (link_start),
        .power_good   (power_good),
        .pll_lock     (pll_lock),
        .cdr_lock     (cdr_lock),
        .rx_aligned   (rx_aligned),
        .pll_rst      (pll_rst),
        .cdr_rst      (cdr_rst),
        .tx_en        (tx_en),
        .rx_en        (rx_en),
        .rx_align_rst (rx_align_rst),
        .link_up      (link_up),
        .link_fail    (link_fail),
        .link_state   (link_state),
        .retry_cnt    (retry_cnt)
    );

    // {pll_rst, cdr_rst, tx_en, rx_en, rx_align_rst, link_up, link_fail}
    function automatic logic [6:0] spec_outs(input int s);
        case (s)
            0, 1:    return 7'b1100100;
            2:       return 7'b0100100;
            3:       return 7'b0110100;
            4:       return 7'b0011100;
            5:       return 7'b0011000;
            6:       return 7'b0011010;
            7:       return 7'b1100101;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [12:0] exp_vec();
        return {3'(m_state), 3'(m_retry), spec_outs(m_state)};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {link_state, retry_cnt, pll_rst, cdr_rst, tx_en,
                rx_en, rx_align_rst, link_up, link_fail};
    endfunction

    task automatic model_step();
        int  nxt, mon, run, dw, restart;
        bit  acc, expire, abort;
        if (rst) begin
            m_state = 0;
            m_dwell = 0;
            m_run   = 0;
            m_retry = 0;
            return;
        end
        nxt     = m_state;
        expire  = 0;
        restart = 1;
        dw      = m_dwell + 1;
        abort   = !link_start || !power_good;
        mon = (m_state == 2) ? int'(pll_lock) :
              (m_state == 4) ? int'(cdr_lock) :
              (m_state == 5) ? int'(rx_aligned) : 0;
        run = (mon != 0) ? m_run + 1 : 0;
        acc = run >= LF;
        case (m_state)
            0: if (link_start && power_good) nxt = 1;
            1: if (dw >= PRC) nxt = 2;
            2: if (acc) nxt = 3; else if (dw >= PTMO) expire = 1;
            3: if (dw >= CRC) nxt = 4;
            4: begin
                restart = 3;
                if (acc) nxt = 5; else if (dw >= CTMO) expire = 1;
            end
            5: begin
                restart = 3;
                if (acc) nxt = 6; else if (dw >= ATMO) expire = 1;
            end
            6: begin
                if (!pll_lock) nxt = 1;
                else if (!cdr_lock || !rx_aligned) nxt = 3;
            end
            default: nxt = m_state;
        endcase
        if (expire) begin
            nxt = (m_retry == MR - 1) ? 7 : restart;
            m_retry = (m_retry < 7) ? m_retry + 1 : 7;
        end
        if (nxt == 6 && m_state != 6) m_retry = 0;
        if (abort) begin
            nxt = 0;
            m_retry = 0;
        end
        if (abort || nxt != m_state) begin
            m_dwell = 0;
            m_run   = 0;
        end else begin
            m_dwell = dw;
            m_run   = run;
        end
        m_state = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_ref_24m);
        #1;
    endtask

    task automatic set_all(input bit ls, pg, pl, cl, ra);
        link_start = ls;
        power_good = pg;
        pll_lock   = pl;
        cdr_lock   = cl;
        rx_aligned = ra;
    endtask

    task automatic advance_to(input int target, input int budget,
                              output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (link_state == 3'(target)) break;
            tick();
        end
        ok = (link_state == 3'(target));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_all(1, 1, 1, 1, 1);
        tick();
        tick();
        checks++;
        if ({link_state, retry_cnt} !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 00",
                     {link_state, retry_cnt});
        end
        checks++;
        if ({pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up,
             link_fail} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 1110000",
                     {pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en,
                      link_up, link_fail});
        end
        rst = 1'b0;
        link_start = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h",
                     obs_vec(), exp_vec());
        end
    endtask

    task automatic test_happy();
        int  seq[$];
        int  first_up = -1;
        int  prc = 0;
        int  last = int'(link_state);
        bit  tx_early = 0;
        bit  tx_cdr = 0;
        bit  bad;
        set_all(1, 1, 1, 1, 1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL happy_cyc%0d: got %h expected %h",
                         i, obs_vec(), exp_vec());
            end
            if (int'(link_state) != last) begin
                seq.push_back(int'(link_state));
                last = int'(link_state);
                if (link_state == 3'd3) tx_cdr = tx_en;
            end
            if (pll_rst) prc++;
            if (tx_en && link_state < 3'd3) tx_early = 1;
            if (link_up && first_up < 0) first_up = i;
        end
        bad = (seq.size() != 6);
        for (int k = 0; k < seq.size() && !bad; k++)
            if (seq[k] != k + 1) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL happy_seq: got %p expected 1..6", seq);
        end
        checks++;
        if (first_up != 1 + PRC + LF + CRC + LF + LF) begin
            errors++;
            $display("FAIL happy_up_cycle: got %0d expected %0d",
                     first_up, 1 + PRC + LF + CRC + LF + LF);
        end
        checks++;
        if (prc != PRC) begin
            errors++;
            $display("FAIL happy_pll_rst_len: got %0d expected %0d",
                     prc, PRC);
        end
        checks++;
        if (!tx_cdr || tx_early) begin
            errors++;
            $display("FAIL happy_tx_en: got cdr=%0d early=%0d expected 1/0",
                     tx_cdr, tx_early);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        bit pat [6];
        pat = '{1, 1, 0, 1, 1, 1};
        link_start = 1'b0;
        tick();
        set_all(1, 1, 0, 1, 1);
        advance_to(2, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL glitch_reach_wait: got %0d expected 2", link_state);
        end
        for (int i = 0; i < 6; i++) begin
            pll_lock = pat[i];
            tick();
            checks++;
            if (link_state !== ((i == 5) ? 3'd3 : 3'd2)) begin
                errors++;
                $display("FAIL glitch_step%0d: got %0d expected %0d",
                         i, link_state, (i == 5) ? 3 : 2);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_model%0d: got %h expected %h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_retry();
        int rq[$];
        int last = 0;
        int fail_at = -1;
        bit bad;
        link_start = 1'b0;
        tick();
        set_all(1, 1, 0, 1, 1);
        for (int i = 1; i <= 150 && fail_at < 0; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL retry_cyc%0d: got %h expected %h",
                         i, obs_vec(), exp_vec());
            end
            if (int'(retry_cnt) != last) begin
                last = int'(retry_cnt);
                rq.push_back(last);
            end
            if (link_state == 3'd7) fail_at = i;
        end
        checks++;
        if (fail_at != 1 + MR * (PRC + PTMO)) begin
            errors++;
            $display("FAIL retry_fail_cycle: got %0d expected %0d",
                     fail_at, 1 + MR * (PRC + PTMO));
        end
        bad = (rq.size() != 3);
        for (int k = 0; k < rq.size() && !bad; k++)
            if (rq[k] != k + 1) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL retry_seq: got %p expected 1,2,3", rq);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({link_state, link_fail, pll_rst} !== 5'b11111) begin
            errors++;
            $display("FAIL retry_fail_hold: got %b expected 11111",
                     {link_state, link_fail, pll_rst});
        end
        link_start = 1'b0;
        tick();
        checks++;
        if ({link_state, retry_cnt, link_fail} !== 7'd0) begin
            errors++;
            $display("FAIL retry_clear: got %b expected 0000000",
                     {link_state, retry_cnt, link_fail});
        end
    endtask

    task automatic test_loss();
        bit ok;
        set_all(1, 1, 1, 1, 1);
        advance_to(6, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL loss_up1: got %0d expected 6", link_state);
        end
        cdr_lock = 1'b0;
        tick();
        cdr_lock = 1'b1;
        checks++;
        if ({link_state, tx_en, rx_en} !== 5'b01110) begin
            errors++;
            $display("FAIL loss_cdr: got %b expected 01110",
                     {link_state, tx_en, rx_en});
        end
        advance_to(6, 40, ok);
        checks++;
        if (!ok || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL loss_up2: got %h expected %h",
                     obs_vec(), exp_vec());
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        checks++;
        if ({link_state, tx_en} !== 4'b0010) begin
            errors++;
            $display("FAIL loss_pll: got %b expected 0010",
                     {link_state, tx_en});
        end
    endtask

    task automatic test_abort();
        bit ok;
        link_start = 1'b0;
        tick();
        set_all(1, 1, 1, 1, 1);
        advance_to(4, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach: got %0d expected 4", link_state);
        end
        power_good = 1'b0;
        tick();
        power_good = 1'b1;
        checks++;
        if ({link_state, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en}
            !== 8'b00011100) begin
            errors++;
            $display("FAIL abort_idle: got %b expected 00011100",
                     {link_state, pll_rst, cdr_rst, rx_align_rst,
                      tx_en, rx_en});
        end
    endtask

    task automatic test_rst_linkup();
        bit ok;
        set_all(1, 1, 1, 1, 1);
        advance_to(6, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_up: got %0d expected 6", link_state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs_vec() !== {6'd0, 7'b1100100}) begin
            errors++;
            $display("FAIL rst_in_up: got %h expected %h",
                     obs_vec(), {6'd0, 7'b1100100});
        end
    endtask

    task automatic test_random();
        int pbad_p = 0, pbad_c = 0, pbad_a = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                pbad_p = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 6);
                pbad_c = ($urandom_range(0, 3) == 0) ? 60 : $urandom_range(0, 6);
                pbad_a = ($urandom_range(0, 3) == 0) ? 60 : $urandom_range(0, 6);
            end
            rst        = ($urandom_range(0, 299) == 0);
            link_start = ($urandom_range(0, 149) != 0);
            power_good = ($urandom_range(0, 199) != 0);
            pll_lock   = ($urandom_range(0, 99) >= pbad_p);
            cdr_lock   = ($urandom_range(0, 99) >= pbad_c);
            rx_aligned = ($urandom_range(0, 99) >= pbad_a);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cyc%0d: got %h expected %h",
                         i, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_all(0, 0, 0, 0, 0);
        m_state = 0;
        m_dwell = 0;
        m_run   = 0;
        m_retry = 0;
        test_reset();
        test_happy();
        test_glitch();
        test_retry();
        test_loss();
        test_abort();
        test_rst_linkup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
